c64_debug_arbiter: RTL and testbench

C64_DEBUG_ARBITER -- requirements
Module: c64_debug_arbiter

---
 rtl/c64_debug_arbiter_pkg.sv | 20 ++
 rtl/c64_debug_arbiter_rr.sv | 16 +
 rtl/c64_debug_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_c64_debug_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/c64_debug_arbiter_pkg.sv
// Shared definitions for the C64 debug arbiter: FSM encoding, timing defaults
// and requester indices.
package c64_debug_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    WAIT_SLOT,
    ACCESS,
    LATENCY,
    DONE
  } dbg_state_t;

  localparam int MEM_LAT_DEFAULT      = 1;
  localparam int HALT_TIMEOUT_DEFAULT = 4;

  localparam logic REQ_UART   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/c64_debug_arbiter_rr.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to the
// requester named by ptr.
module debug_rr_pick2
  import c64_debug_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic grant,
  output logic valid
);

  assign valid = req0 | req1;
  assign grant = (req0 & req1) ? ptr : (req1 ? REQ_LOADER : REQ_UART);

endmodule

// File: rtl/c64_debug_arbiter.sv
// Arbitrates two debug requesters onto the shared C64 memory port, halting the
// 6502 via RDY and slotting each access into a CPU bus half-cycle.
module c64_debug_arbiter
  import c64_debug_arbiter_pkg::*;
#(
  parameter int MEM_LAT      = MEM_LAT_DEFAULT,
  parameter int HALT_TIMEOUT = HALT_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  input  logic        cpu_slot,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_en,
  input  logic [7:0]  mem_rdata
);

  localparam int SW = $clog2(HALT_TIMEOUT + 1);

  dbg_state_t state, state_n;
  logic          gnt, gnt_n, ptr, ptr_n;
  logic [15:0]   lat_addr, lat_addr_n;
  logic [7:0]    lat_wdata, lat_wdata_n;
  logic          lat_we, lat_we_n;
  logic [SW-1:0] slot_cnt, slot_n;
  logic [2:0]    lat_cnt, lat_n;
  logic          ack0_n, ack1_n, cpu_rdy_n, mem_en_n, mem_we_n;
  logic [15:0]   mem_addr_n;
  logic [7:0]    mem_wdata_n, rdata_n;
  logic          pick_gnt, pick_valid;
  logic          req_g, req_o;
  logic          load, load_sel;

  debug_rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .ptr   (ptr),
    .grant (pick_gnt),
    .valid (pick_valid)
  );

  assign req_g = gnt ? req1 : req0;
  assign req_o = gnt ? req0 : req1;

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    ptr_n       = ptr;
    lat_addr_n  = lat_addr;
    lat_wdata_n = lat_wdata;
    lat_we_n    = lat_we;
    slot_n      = slot_cnt;
    lat_n       = lat_cnt;
    ack0_n      = ack0;
    ack1_n      = ack1;
    cpu_rdy_n   = cpu_rdy;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    rdata_n     = rdata;
    load        = 1'b0;
    load_sel    = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          load      = 1'b1;
          load_sel  = pick_gnt;
          gnt_n     = pick_gnt;
          ptr_n     = ~pick_gnt;
          cpu_rdy_n = 1'b0;
          slot_n    = '0;
          state_n   = HALT;
        end
      end
      HALT: begin
        // A read slot means the CPU is stalled; writes never stall, so time out.
        if (cpu_slot) begin
          if (cpu_rw || (slot_cnt >= SW'(HALT_TIMEOUT - 1)))
            state_n = WAIT_SLOT;
          if (slot_cnt != SW'(HALT_TIMEOUT))
            slot_n = slot_cnt + 1'b1;
        end
      end
      WAIT_SLOT: begin
        if (cpu_slot) begin
          mem_en_n    = 1'b1;
          mem_we_n    = lat_we;
          mem_addr_n  = lat_addr;
          mem_wdata_n = lat_wdata;
          state_n     = ACCESS;
        end
      end
      ACCESS: begin
        lat_n   = '0;
        state_n = LATENCY;
      end
      LATENCY: begin
        if (lat_cnt == 3'(MEM_LAT - 1)) begin
          if (!lat_we)
            rdata_n = mem_rdata;
          if (gnt)
            ack1_n = 1'b1;
          else
            ack0_n = 1'b1;
          state_n = DONE;
        end else begin
          lat_n = lat_cnt + 3'd1;
        end
      end
      DONE: begin
        // Hand straight over to a waiting requester while the CPU is still halted.
        if (!req_g) begin
          ack0_n = 1'b0;
          ack1_n = 1'b0;
          if (req_o) begin
            load     = 1'b1;
            load_sel = ~gnt;
            gnt_n    = ~gnt;
            ptr_n    = gnt;
            state_n  = WAIT_SLOT;
          end else begin
            cpu_rdy_n = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      lat_addr_n  = load_sel ? addr1 : addr0;
      lat_wdata_n = load_sel ? wdata1 : wdata0;
      lat_we_n    = load_sel ? we1 : we0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= REQ_UART;
      ptr       <= REQ_UART;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      slot_cnt  <= '0;
      lat_cnt   <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      cpu_rdy   <= 1'b1;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      ptr       <= ptr_n;
      lat_addr  <= lat_addr_n;
      lat_wdata <= lat_wdata_n;
      lat_we    <= lat_we_n;
      slot_cnt  <= slot_n;
      lat_cnt   <= lat_n;
      ack0      <= ack0_n;
      ack1      <= ack1_n;
      cpu_rdy   <= cpu_rdy_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      rdata     <= rdata_n;
    end
  end

endmodule

// File: tb/tb_c64_debug_arbiter.sv
// Directed bench for c64_debug_arbiter: a vector table of single transactions
// plus hand-written arbitration, reset and MEM_LAT=3 sequences.
module tb_c64_debug_arbiter;

  typedef struct {
    logic        id;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        cpu_rw;
    logic [7:0]  mem_data;
    logic [7:0]  exp_rdata;
    int          exp_slots;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1, we0, we1, ack0, ack1;
  logic [15:0] addr0, addr1, mem_addr;
  logic [7:0]  wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic        cpu_slot, cpu_rw, cpu_rdy, mem_we, mem_en;

  logic        req0_b, ack0_b, ack1_b, cpu_rdy_b, mem_we_b, mem_en_b;
  logic [15:0] addr0_b, mem_addr_b;
  logic [7:0]  rdata_b, mem_wdata_b, mem_rdata_b;

  int total = 0;
  int bad   = 0;

  c64_debug_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .cpu_slot(cpu_slot), .cpu_rw(cpu_rw), .cpu_rdy(cpu_rdy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_en(mem_en), .mem_rdata(mem_rdata)
  );

  c64_debug_arbiter #(.MEM_LAT(3)) dut_lat3 (
    .clk(clk), .reset(reset),
    .req0(req0_b), .req1(1'b0), .addr0(addr0_b), .addr1(16'h0000),
    .wdata0(8'h00), .wdata1(8'h00), .we0(1'b0), .we1(1'b0),
    .ack0(ack0_b), .ack1(ack1_b), .rdata(rdata_b),
    .cpu_slot(cpu_slot), .cpu_rw(cpu_rw), .cpu_rdy(cpu_rdy_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b),
    .mem_en(mem_en_b), .mem_rdata(mem_rdata_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Pulse cpu_slot every 4th clock until ack (or mem_en) shows, recording the access.
  task automatic runSlots(input logic rw, input logic stop_on_en,
                          output int en_cnt, output int we_cnt, output int slots_at_en,
                          output logic [15:0] en_addr, output logic [7:0] en_wdata,
                          output logic rdy_rose, output logic ok);
    int slots;
    slots = 0; en_cnt = 0; we_cnt = 0; slots_at_en = -1;
    en_addr = '0; en_wdata = '0; rdy_rose = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cpu_rw   = rw;
      cpu_slot = (i % 4 == 0);
      if (cpu_slot) slots++;
      tick();
      cpu_slot = 1'b0;
      if (cpu_rdy) rdy_rose = 1'b1;
      if (mem_en) begin
        if (en_cnt == 0) begin
          slots_at_en = slots;
          en_addr     = mem_addr;
          en_wdata    = mem_wdata;
        end
        en_cnt++;
      end
      if (mem_we) we_cnt++;
      if (stop_on_en && mem_en) begin ok = 1'b1; break; end
      if (ack0 | ack1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int en_cnt, we_cnt, slots;
    logic [15:0] a;
    logic [7:0] d;
    logic rose, ok;
    mem_rdata = v.mem_data;
    if (!v.id) begin
      addr0 = v.addr; wdata0 = v.wdata; we0 = v.we; req0 = 1'b1;
    end else begin
      addr1 = v.addr; wdata1 = v.wdata; we1 = v.we; req1 = 1'b1;
    end
    tick();
    checkOutput("halt_rdy_low", cpu_rdy, 0);
    runSlots(v.cpu_rw, 1'b0, en_cnt, we_cnt, slots, a, d, rose, ok);
    checkOutput("ack_seen", ok, 1);
    checkOutput("en_pulses", en_cnt, 1);
    checkOutput("we_pulses", we_cnt, v.we);
    checkOutput("slots_to_access", slots, v.exp_slots);
    checkOutput("mem_addr", a, v.addr);
    if (v.we) checkOutput("mem_wdata", d, v.wdata);
    checkOutput("ack_id", {ack1, ack0}, v.id ? 2'b10 : 2'b01);
    checkOutput("rdata", rdata, v.exp_rdata);
    checkOutput("rdy_stayed_low", rose, 0);
    tick();
    checkOutput("ack_hold", {ack1, ack0}, v.id ? 2'b10 : 2'b01);
    if (!v.id) req0 = 1'b0; else req1 = 1'b0;
    tick();
    checkOutput("ack_fall", {ack1, ack0}, 0);
    checkOutput("rdy_back", cpu_rdy, 1);
  endtask

  vec_t vecs[5];

  initial begin
    int en_cnt, we_cnt, slots, ke, kack;
    logic [15:0] a;
    logic [7:0] d;
    logic rose, ok;

    vecs[0] = '{1'b0, 16'hD020, 8'h00, 1'b0, 1'b1, 8'h0E, 8'h0E, 2};
    vecs[1] = '{1'b1, 16'h0801, 8'hA9, 1'b1, 1'b0, 8'h55, 8'h0E, 5};
    vecs[2] = '{1'b0, 16'hC000, 8'h00, 1'b0, 1'b1, 8'h11, 8'h11, 2};
    vecs[3] = '{1'b0, 16'hC001, 8'h00, 1'b0, 1'b1, 8'h22, 8'h22, 2};
    vecs[4] = '{1'b1, 16'h1234, 8'h00, 1'b0, 1'b0, 8'h77, 8'h77, 5};

    reset = 1'b1; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    we0 = 0; we1 = 0; cpu_slot = 0; cpu_rw = 1; mem_rdata = 0;
    req0_b = 0; addr0_b = 0; mem_rdata_b = 0;
    tick(); tick();
    checkOutput("rst_rdy", cpu_rdy, 1);
    checkOutput("rst_ack", {ack1, ack0}, 0);
    checkOutput("rst_mem_en_we", {mem_en, mem_we}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_rdy_lat3", cpu_rdy_b, 1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Simultaneous requests from reset: 0 first, handoff to 1 without re-halt.
    reset = 1'b1; tick(); reset = 1'b0;
    addr0 = 16'hA000; we0 = 0; addr1 = 16'hB000; we1 = 0; mem_rdata = 8'h5A;
    req0 = 1; req1 = 1;
    tick();
    checkOutput("pair_rdy_low", cpu_rdy, 0);
    runSlots(1'b1, 1'b0, en_cnt, we_cnt, slots, a, d, rose, ok);
    checkOutput("pair1_ack", {ack1, ack0}, 2'b01);
    checkOutput("pair1_addr", a, 16'hA000);
    req0 = 0;
    tick();
    checkOutput("handoff_ack_fall", {ack1, ack0}, 0);
    checkOutput("handoff_rdy_low", cpu_rdy, 0);
    runSlots(1'b1, 1'b0, en_cnt, we_cnt, slots, a, d, rose, ok);
    checkOutput("pair2_ack", {ack1, ack0}, 2'b10);
    checkOutput("pair2_addr", a, 16'hB000);
    checkOutput("pair2_no_rehalt_slots", slots, 1);
    checkOutput("pair2_rdy_stayed_low", rose, 0);
    req1 = 0;
    tick();
    checkOutput("pair_rdy_back", cpu_rdy, 1);

    req0 = 1; req1 = 1;
    tick();
    runSlots(1'b1, 1'b0, en_cnt, we_cnt, slots, a, d, rose, ok);
    checkOutput("pair3_ack", {ack1, ack0}, 2'b01);
    checkOutput("pair3_addr", a, 16'hA000);
    req0 = 0;
    tick();
    // Requester 1 withdraws before its ack: access still completes, ack pulses once.
    req1 = 0;
    runSlots(1'b1, 1'b0, en_cnt, we_cnt, slots, a, d, rose, ok);
    checkOutput("drop_ack_seen", ack1, 1);
    checkOutput("drop_en_pulses", en_cnt, 1);
    tick();
    checkOutput("drop_ack_pulse", ack1, 0);
    checkOutput("drop_rdy_back", cpu_rdy, 1);

    // Reset in LATENCY.
    addr0 = 16'h2000; we0 = 0; req0 = 1;
    tick();
    runSlots(1'b1, 1'b1, en_cnt, we_cnt, slots, a, d, rose, ok);
    checkOutput("lat_reach_access", ok, 1);
    tick();
    reset = 1'b1; req0 = 0;
    tick();
    checkOutput("mid_rst_rdy", cpu_rdy, 1);
    checkOutput("mid_rst_en", mem_en, 0);
    checkOutput("mid_rst_ack", {ack1, ack0}, 0);
    checkOutput("mid_rst_rdata", rdata, 0);
    checkOutput("mid_rst_addr", mem_addr, 0);
    reset = 1'b0;
    tick();
    checkOutput("post_rst_idle_rdy", cpu_rdy, 1);
    applyStimulus('{1'b0, 16'h2001, 8'h00, 1'b0, 1'b1, 8'h3C, 8'h3C, 2});

    // MEM_LAT=3 instance: mem_rdata_b is cycle-stamped to expose the sample point.
    addr0_b = 16'h3000; req0_b = 1; cpu_rw = 1; ke = -1; kack = -1;
    for (int k = 0; k < 200; k++) begin
      mem_rdata_b = 8'(8'h40 + k);
      cpu_slot = (k % 4 == 0);
      tick();
      cpu_slot = 1'b0;
      if (mem_en_b && ke < 0) ke = k;
      if (ack0_b) begin kack = k; break; end
    end
    checkOutput("lat3_ack_seen", (kack >= 0), 1);
    checkOutput("lat3_addr", mem_addr_b, 16'h3000);
    checkOutput("lat3_rdata", rdata_b, 8'(8'h40 + ke + 4));
    checkOutput("lat3_ack_delay", kack - ke, 4);
    req0_b = 0;
    tick();
    checkOutput("lat3_ack_fall", ack0_b, 0);
    checkOutput("lat3_rdy_back", cpu_rdy_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
